// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Purpose:
//   Front-end between hps_io joystick words and an arcade core's player
//   inputs. For each of PLAYERS channels it selects the control source
//   (own pad or the OR of all pads), cancels opposing directions, passes
//   fire/start through, and shapes the coin bit into a fixed-length pulse
//   followed by a lockout gap. Every output bit is registered.
//
// Parameters:
//   PLAYERS        number of player channels (1..4)
//   BUTTONS        fire buttons per player (1..8), source bits [4+BUTTONS-1:4]
//   COIN_PULSE     coin output high time in clk_sys cycles (>=1)
//   COIN_GAP       lockout after the pulse in clk_sys cycles (>=0)
//   AUTOFIRE_HALF  autofire half-period in cycles (autofire build only)
//
// Ports:
//   clk_sys     in   1                    single clock
//   reset_n     in   1                    synchronous, active-low reset
//   joy_in      in   16*PLAYERS           player p at [16p+15:16p];
//                                         bit 0 right, 1 left, 2 down, 3 up,
//                                         4..3+BUTTONS fire, 4+BUTTONS start,
//                                         5+BUTTONS coin
//   shared      in   1                    1 = directions/fire from OR of pads
//   autofire    in   PLAYERS              per-player autofire on fire 0
//   player_out  out  (BUTTONS+6)*PLAYERS  per player
//                                         {coin,start,fire[BUTTONS-1:0],
//                                          right,left,down,up}
//
// Build option:
//   INPUT_MAPPER_AUTOFIRE_EN  when defined, a free-running counter toggles an
//                             autofire phase every AUTOFIRE_HALF cycles; a
//                             player with autofire set and fire 0 held sees
//                             fire 0 = phase. When undefined, no autofire
//                             logic exists and fire 0 always passes through.
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
  parameter int PLAYERS       = 2,
  parameter int BUTTONS       = 1,
  parameter int COIN_PULSE    = 12000,
  parameter int COIN_GAP      = 6000,
  parameter int AUTOFIRE_HALF = 600000
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [16*PLAYERS-1:0]           joy_in,
  input  logic                            shared,
  input  logic [PLAYERS-1:0]              autofire,
  output logic [(BUTTONS+6)*PLAYERS-1:0]  player_out
);

  // Per-player output width and the number of source bits that can be shared
  // (four directions plus the fire buttons).
  localparam int OUT_W  = BUTTONS + 6;
  localparam int CTRL_W = 4 + BUTTONS;

  // Coin counter sized for the longer of the two timed phases.
  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (COIN_GAP > 0) ? CNT_W'(COIN_GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_t;

  // ---------------------------------------------------------------------------
  // Shared-control source: bitwise OR of every pad's directions and fire bits.
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0] w_joy_or;

  // NOTE: a combinational block assigns every output a default before any
  // branch so that no path leaves a value held, which would infer a latch.
  always_comb begin
    w_joy_or = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_joy_or = w_joy_or | joy_in[16*p +: CTRL_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Autofire phase generator (optional).
  // ---------------------------------------------------------------------------
  logic               w_af_phase;
  logic [PLAYERS-1:0] w_af_en;

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  localparam int AF_W = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

  logic [AF_W-1:0] r_af_cnt;
  logic            r_af_phase;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AF_W'(AUTOFIRE_HALF - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 1'b1;
    end
  end

  assign w_af_phase = r_af_phase;
  assign w_af_en    = autofire;

  // Sink for the joystick bits above coin, which no player reads.
  logic w_unused_inputs;
  assign w_unused_inputs = ^joy_in;
`else
  assign w_af_phase = 1'b0;
  assign w_af_en    = '0;

  // Sink for inputs this build leaves unread: the autofire enables, the
  // autofire period, and the joystick bits above coin.
  logic w_unused_inputs;
  assign w_unused_inputs = (^autofire) ^ (^joy_in) ^ (AUTOFIRE_HALF > 0);
`endif

  // ---------------------------------------------------------------------------
  // Per-player datapath and coin pulse shaper.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [CTRL_W-1:0]  w_src;
    logic               w_up;
    logic               w_down;
    logic               w_left;
    logic               w_right;
    logic [BUTTONS-1:0] w_fire;
    logic               w_start;
    logic               w_coin;
    logic               w_coin_rise;

    coin_state_t        r_state;
    coin_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_coin_prev;
    logic [OUT_W-1:0]   r_out;

    // Directions and fire follow the shared source; start and coin are
    // always the player's own.
    assign w_src   = shared ? w_joy_or : joy_in[16*p +: CTRL_W];
    assign w_start = joy_in[16*p + 4 + BUTTONS];
    assign w_coin  = joy_in[16*p + 5 + BUTTONS];

    // Opposing pairs cancel to neutral rather than favouring either side.
    assign w_right = w_src[0] & ~w_src[1];
    assign w_left  = w_src[1] & ~w_src[0];
    assign w_down  = w_src[2] & ~w_src[3];
    assign w_up    = w_src[3] & ~w_src[2];

    always_comb begin
      w_fire = w_src[4 +: BUTTONS];
      if (w_af_en[p] && w_src[4]) begin
        w_fire[0] = w_af_phase;
      end
    end

    // r_coin_prev comes out of reset high, so a coin held across reset
    // release is not mistaken for a fresh press.
    assign w_coin_rise = w_coin & ~r_coin_prev;

    // Coin FSM: presses are only accepted in IDLE; anything seen during the
    // pulse or the lockout is dropped, never queued.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
        ST_IDLE: begin
          if (w_coin_rise) begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = PULSE_LOAD;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            if (COIN_GAP > 0) begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = GAP_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // The coin output is taken from the next state, so the output register
    // goes high on the same edge that enters PULSE and drops on the edge
    // that leaves it, giving exactly COIN_PULSE high cycles.
    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_coin_prev <= 1'b1;
        r_out       <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_coin_prev <= w_coin;
        r_out       <= {(w_state_nxt == ST_PULSE), w_start, w_fire,
                        w_right, w_left, w_down, w_up};
      end
    end

    assign player_out[OUT_W*p +: OUT_W] = r_out;
  end

endmodule
